// File: rtl/matrix_job_scheduler.sv
// -----------------------------------------------------------------------------
// matrix_job_scheduler
//   Queues matrix-multiply jobs from the host in a DEPTH-entry command FIFO and
//   issues them one at a time to the matrix multiply engine over a start/done
//   handshake. A per-job watchdog aborts jobs that do not finish within TIMEOUT
//   cycles. Every job produces exactly one tagged completion record.
//
// Ports
//   clk, rst             clock / asynchronous active-high reset
//   cmd_valid/ready      host job handshake; cmd_addr, cmd_mode, cmd_tag payload
//   eng_start            one-cycle start pulse to the engine
//   eng_addr, eng_mode   job parameters, stable from start until done/abort
//   eng_abort            one-cycle pulse forcing the engine back to idle
//   eng_done             engine finished the current job (single-cycle pulse)
//   cpl_valid/ready      completion handshake; cpl_tag, cpl_error payload
//   busy                 scheduler has work (FSM active or FIFO non-empty)
//   level                FIFO occupancy
// -----------------------------------------------------------------------------
module matrix_job_scheduler #(
   parameter int DEPTH   = 4,
   parameter int TAG_W   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [31:0]              cmd_addr,
   input  logic                     cmd_mode,
   input  logic [TAG_W-1:0]         cmd_tag,
   output logic                     eng_start,
   output logic [31:0]              eng_addr,
   output logic                     eng_mode,
   output logic                     eng_abort,
   input  logic                     eng_done,
   output logic                     cpl_valid,
   input  logic                     cpl_ready,
   output logic [TAG_W-1:0]         cpl_tag,
   output logic                     cpl_error,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;
   // Watchdog only needs to reach TIMEOUT-1.
   localparam int WD_W  = $clog2(TIMEOUT);

   typedef struct packed {
      logic [31:0]      addr;
      logic             mode;
      logic [TAG_W-1:0] tag;
   } job_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_CPL
   } state_t;

   state_t            state;
   job_t              fifo_mem [DEPTH];
   job_t              job;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [LVL_W-1:0]  count;
   logic [WD_W-1:0]   wd;
   logic              push;
   logic              pop;

   assign cmd_ready = (count != LVL_W'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   // The FIFO is drained only when the FSM takes a new job.
   assign pop       = (state == S_IDLE) && (count != '0);
   assign level     = count;
   assign busy      = (state != S_IDLE) || (count != '0);

   // Engine and completion payload come straight from the latched job, so they
   // stay stable for the whole start..done and valid..ready windows.
   assign eng_addr  = job.addr;
   assign eng_mode  = job.mode;
   assign cpl_tag   = job.tag;

   // ---------------------------------------------------------------- FIFO
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= '{addr: cmd_addr, mode: cmd_mode, tag: cmd_tag};
   end

   // DEPTH is a power of two, so plain pointer overflow gives the wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + LVL_W'(1);
            2'b01:   count <= count - LVL_W'(1);
            default: count <= count;
         endcase
      end
   end

   // ---------------------------------------------------------------- FSM
   // All handshake outputs are registered: each is set on the edge that
   // makes the decision and is visible during the following cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         job       <= '0;
         wd        <= '0;
         eng_start <= 1'b0;
         eng_abort <= 1'b0;
         cpl_valid <= 1'b0;
         cpl_error <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         eng_abort <= 1'b0;
         case (state)
            S_IDLE: begin
               if (pop) begin
                  job   <= fifo_mem[rd_ptr];
                  state <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               eng_start <= 1'b1;
               wd        <= '0;
               state     <= S_WAIT;
            end
            S_WAIT: begin
               // A done arriving on the final watchdog cycle still counts
               // as a clean completion.
               if (eng_done) begin
                  cpl_valid <= 1'b1;
                  cpl_error <= 1'b0;
                  state     <= S_CPL;
               end else if (wd == WD_W'(TIMEOUT - 1)) begin
                  eng_abort <= 1'b1;
                  cpl_valid <= 1'b1;
                  cpl_error <= 1'b1;
                  state     <= S_CPL;
               end else begin
                  wd <= wd + WD_W'(1);
               end
            end
            S_CPL: begin
               if (cpl_ready) begin
                  cpl_valid <= 1'b0;
                  cpl_error <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_job_scheduler.sv
module tb_matrix_job_scheduler;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_addr = '0;
   logic        cmd_mode = 1'b0;
   logic [3:0]  cmd_tag = '0;
   logic        eng_start;
   logic [31:0] eng_addr;
   logic        eng_mode;
   logic        eng_abort;
   logic        eng_done = 1'b0;
   logic        cpl_valid;
   logic        cpl_ready = 1'b0;
   logic [3:0]  cpl_tag;
   logic        cpl_error;
   logic        busy;
   logic [2:0]  level;

   int checks = 0;
   int errors = 0;
   int start_cnt = 0;
   int abort_cnt = 0;

   matrix_job_scheduler #(.DEPTH(4), .TAG_W(4), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_mode(cmd_mode), .cmd_tag(cmd_tag),
      .eng_start(eng_start), .eng_addr(eng_addr), .eng_mode(eng_mode),
      .eng_abort(eng_abort), .eng_done(eng_done),
      .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag),
      .cpl_error(cpl_error), .busy(busy), .level(level)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (eng_start === 1'b1) start_cnt++;
      if (eng_abort === 1'b1) abort_cnt++;
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset(input string p);
      chk({p, "_cmd_ready"}, cmd_ready, 1);
      chk({p, "_eng_start"}, eng_start, 0);
      chk({p, "_eng_addr"},  eng_addr, 0);
      chk({p, "_eng_mode"},  eng_mode, 0);
      chk({p, "_eng_abort"}, eng_abort, 0);
      chk({p, "_cpl_valid"}, cpl_valid, 0);
      chk({p, "_cpl_tag"},   cpl_tag, 0);
      chk({p, "_cpl_error"}, cpl_error, 0);
      chk({p, "_busy"},      busy, 0);
      chk({p, "_level"},     level, 0);
   endtask

   task automatic wait_start(input string tag);
      int n;
      n = 0;
      while (eng_start !== 1'b1 && n < 20) begin
         cyc();
         n++;
      end
      chk(tag, eng_start, 1);
   endtask

   // Engine finishes dly cycles after now; completion is checked and accepted.
   task automatic finish_job(input logic [3:0] tag, input int dly);
      repeat (dly) cyc();
      eng_done = 1'b1;
      cyc();
      eng_done = 1'b0;
      chk("cpl_valid", cpl_valid, 1);
      chk("cpl_tag", cpl_tag, 32'(tag));
      chk("cpl_error", cpl_error, 0);
      cpl_ready = 1'b1;
      cyc();
      cpl_ready = 1'b0;
      chk("cpl_drop", cpl_valid, 0);
   endtask

   task automatic run_job(input logic [3:0] tag, input logic [31:0] addr,
                          input logic mode, input int dly);
      wait_start("start_seen");
      chk("eng_addr", eng_addr, addr);
      chk("eng_mode", eng_mode, 32'(mode));
      finish_job(tag, dly);
   endtask

   task automatic push(input logic [3:0] tag, input logic [31:0] addr, input logic mode);
      cmd_valid = 1'b1;
      cmd_tag   = tag;
      cmd_addr  = addr;
      cmd_mode  = mode;
      cyc();
      cmd_valid = 1'b0;
   endtask

   initial begin
      int s0;
      logic ok;

      // ---- reset state
      cyc(); cyc();
      chk_reset("rst");
      rst = 1'b0;
      cyc();

      // ---- single job, start latency 2 cycles after push edge
      cmd_valid = 1'b1; cmd_addr = 32'h100; cmd_mode = 1'b1; cmd_tag = 4'd3;
      cyc();
      cmd_valid = 1'b0;
      chk("t1_level1", level, 1);
      chk("t1_busy", busy, 1);
      chk("t1_nostart_a", eng_start, 0);
      cyc();
      chk("t1_nostart_b", eng_start, 0);
      chk("t1_level0", level, 0);
      cyc();
      chk("t1_start", eng_start, 1);
      chk("t1_addr", eng_addr, 32'h100);
      chk("t1_mode", eng_mode, 1);
      cyc();
      chk("t1_start_pulse", eng_start, 0);
      finish_job(4'd3, 11);
      chk("t1_idle", busy, 0);
      chk("t1_starts", start_cnt, 1);

      // ---- five jobs into a 4-deep FIFO, in-order completion
      s0 = start_cnt;
      for (int k = 0; k < 5; k++) begin
         cmd_valid = 1'b1;
         cmd_tag   = 4'(k);
         cmd_addr  = 32'(32'h1000 + k * 64);
         cmd_mode  = 1'(k & 1);
         cyc();
         if (k == 2) chk("t2_start0", eng_start, 1);
      end
      chk("t2_full_level", level, 4);
      chk("t2_full_ready", cmd_ready, 0);
      cmd_tag = 4'hf; cmd_addr = 32'hdead;
      cyc();
      cmd_valid = 1'b0;
      chk("t2_push_ignored", level, 4);
      chk("t2_addr0", eng_addr, 32'h1000);
      finish_job(4'd0, 1);
      chk("t2_still_full", cmd_ready, 0);
      cyc();
      chk("t2_pop_level", level, 3);
      chk("t2_pop_ready", cmd_ready, 1);
      for (int k = 1; k < 5; k++)
         run_job(4'(k), 32'(32'h1000 + k * 64), 1'(k & 1), 1);
      chk("t2_starts", start_cnt - s0, 5);

      // ---- watchdog abort, then the next queued job issues normally
      cmd_valid = 1'b1; cmd_tag = 4'd5; cmd_addr = 32'h200; cmd_mode = 1'b0;
      cyc();
      cmd_tag = 4'd6; cmd_addr = 32'h300; cmd_mode = 1'b1;
      cyc();
      cmd_valid = 1'b0;
      wait_start("t3_start");
      chk("t3_addr", eng_addr, 32'h200);
      ok = 1'b1;
      repeat (15) begin
         cyc();
         if (eng_abort !== 1'b0 || cpl_valid !== 1'b0) ok = 1'b0;
      end
      chk("t3_no_early_abort", ok, 1);
      cyc();
      chk("t3_abort", eng_abort, 1);
      chk("t3_cpl_valid", cpl_valid, 1);
      chk("t3_cpl_error", cpl_error, 1);
      chk("t3_cpl_tag", cpl_tag, 5);
      cyc();
      chk("t3_abort_pulse", eng_abort, 0);
      chk("t3_cpl_hold", cpl_valid, 1);
      cpl_ready = 1'b1;
      cyc();
      cpl_ready = 1'b0;
      run_job(4'd6, 32'h300, 1'b1, 1);

      // ---- done on the last watchdog cycle: done wins
      push(4'd7, 32'h400, 1'b1);
      wait_start("t4_start");
      repeat (15) cyc();
      eng_done = 1'b1;
      cyc();
      eng_done = 1'b0;
      chk("t4_no_abort", eng_abort, 0);
      chk("t4_cpl_valid", cpl_valid, 1);
      chk("t4_cpl_error", cpl_error, 0);
      chk("t4_cpl_tag", cpl_tag, 7);
      cpl_ready = 1'b1;
      cyc();
      cpl_ready = 1'b0;

      // ---- completion back-pressure with a job queued; stray done ignored
      cmd_valid = 1'b1; cmd_tag = 4'd8; cmd_addr = 32'h500; cmd_mode = 1'b0;
      cyc();
      cmd_tag = 4'd9; cmd_addr = 32'h600;
      cyc();
      cmd_valid = 1'b0;
      wait_start("t5_start");
      chk("t5_addr", eng_addr, 32'h500);
      cyc();
      eng_done = 1'b1;
      cyc();
      eng_done = 1'b0;
      s0 = start_cnt;
      ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (cpl_valid !== 1'b1 || cpl_tag !== 4'd8 || cpl_error !== 1'b0 ||
             eng_start !== 1'b0 || level !== 3'd1) ok = 1'b0;
         eng_done = (i == 4);
         cyc();
      end
      eng_done = 1'b0;
      chk("t5_stable", ok, 1);
      chk("t5_no_start", start_cnt - s0, 0);
      cpl_ready = 1'b1;
      cyc();
      cpl_ready = 1'b0;
      run_job(4'd9, 32'h600, 1'b0, 1);

      // ---- reset during WAIT with two jobs queued
      for (int k = 0; k < 3; k++) begin
         cmd_valid = 1'b1;
         cmd_tag   = 4'(10 + k);
         cmd_addr  = 32'(32'h700 + k * 64);
         cyc();
      end
      cmd_valid = 1'b0;
      chk("t6_start", eng_start, 1);
      chk("t6_level", level, 2);
      repeat (3) cyc();
      rst = 1'b1;
      #1;
      chk_reset("t6_rst");
      cyc(); cyc();
      rst = 1'b0;
      eng_done = 1'b1;
      cyc();
      eng_done = 1'b0;
      s0 = start_cnt;
      ok = 1'b1;
      repeat (20) begin
         if (cpl_valid !== 1'b0 || eng_start !== 1'b0 || eng_abort !== 1'b0 ||
             busy !== 1'b0 || level !== 3'd0) ok = 1'b0;
         cyc();
      end
      chk("t6_quiet", ok, 1);
      chk("t6_no_start", start_cnt - s0, 0);

      // ---- totals
      chk("total_starts", start_cnt, 12);
      chk("total_aborts", abort_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
